// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int ADDRESS   = 32,
    parameter int DATA      = 32,
    parameter int LS_STREAK = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDRESS-1:0]  if_addr,
    output logic [DATA-1:0]     if_rdata,
    output logic                if_valid,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA/8-1:0]   ls_mask,
    input  logic [ADDRESS-1:0]  ls_addr,
    input  logic [DATA-1:0]     ls_wdata,
    output logic [DATA-1:0]     ls_rdata,
    output logic                ls_valid,
    output logic                mem_request,
    output logic                mem_we_re,
    output logic [DATA/8-1:0]   mem_mask,
    output logic [ADDRESS-1:0]  mem_addr,
    output logic [DATA-1:0]     mem_wdata,
    input  logic [DATA-1:0]     mem_rdata,
    input  logic                mem_valid,
    output logic                bus_err
);
    localparam int SW = $clog2(LS_STREAK + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   streak, streak_nxt;
    logic [WW-1:0]   wd_cnt;
    logic            grant_ls, grant_if, done, abort, cooldown;

    // The cycle carrying a valid pulse is spent in IDLE without granting, so the
    // requester that just completed cannot be re-granted on its stale request.
    assign cooldown    = if_valid | ls_valid;
    assign mem_request = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        grant_ls   = 1'b0;
        grant_if   = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!cooldown) begin
                    if (ls_req && (!if_req || streak < STREAK_MAX)) begin
                        grant_ls   = 1'b1;
                        state_nxt  = LS_BUSY;
                        streak_nxt = !if_req ? '0 :
                                     (streak == STREAK_MAX) ? streak : streak + 1'b1;
                    end else if (if_req) begin
                        grant_if   = 1'b1;
                        state_nxt  = IF_BUSY;
                        streak_nxt = '0;
                    end
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (mem_valid)
                    done = 1'b1;
                else if (wd_cnt == WD_LAST)
                    abort = 1'b1;
                if (done || abort)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            wd_cnt    <= '0;
            mem_we_re <= 1'b0;
            mem_mask  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_valid  <= 1'b0;
            ls_valid  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            streak   <= streak_nxt;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            bus_err  <= 1'b0;
            if (grant_ls || grant_if) begin
                wd_cnt    <= '0;
                mem_addr  <= grant_ls ? ls_addr : if_addr;
                mem_we_re <= grant_ls & ls_we;
                mem_mask  <= grant_ls ? ls_mask : '1;
                mem_wdata <= grant_ls ? ls_wdata : '0;
            end else if (state != IDLE && !done && !abort) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (done || abort) begin
                mem_we_re <= 1'b0;
                mem_mask  <= '0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                bus_err   <= abort;
                if (state == IF_BUSY) begin
                    if_valid <= 1'b1;
                    if_rdata <= done ? mem_rdata : '0;
                end else begin
                    ls_valid <= 1'b1;
                    ls_rdata <= done ? mem_rdata : '0;
                end
            end
        end
    end
endmodule
